// File: rtl/gram_write_scheduler.sv
// Shares the single GRAM write port between buffered UART character writes
// and a full-screen clear sequencer that fills every cell with FILL_CHAR.
module gram_write_scheduler #(
    parameter int unsigned GRAM_DEPTH = 2400,
    parameter logic [6:0]  FILL_CHAR  = 7'h20,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_write_enable,
    input  logic [6:0]  uart_write_data,
    input  logic [11:0] uart_write_address,
    input  logic        clear_req,
    input  logic        overflow_clear,
    output logic        gram_write_enable,
    output logic [6:0]  gram_write_data,
    output logic [11:0] gram_write_address,
    output logic        clear_busy,
    output logic        fifo_overflow
);

    localparam int unsigned DATA_W = 7;
    localparam int unsigned ADDR_W = 12;
    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(GRAM_DEPTH - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_entry_t;

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;

    wr_entry_t         fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              fifo_empty, fifo_full;
    logic              pop, push, drop;
    wr_entry_t         head, push_entry;

    logic              we_d;
    logic [DATA_W-1:0] data_d;
    logic [ADDR_W-1:0] addr_d;
    logic              busy_d;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FULL_CNT);
    assign head       = fifo_mem[rd_ptr_q];
    assign push_entry = '{addr: uart_write_address, data: uart_write_data};

    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign push = uart_write_enable && (!fifo_full || pop);
    assign drop = uart_write_enable && fifo_full && !pop;

    // Next-state and next-output logic; clear wins over a pending pop.
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        we_d      = 1'b0;
        data_d    = gram_write_data;
        addr_d    = gram_write_address;
        busy_d    = clear_busy;
        pop       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (clear_req) begin
                    state_d   = ST_CLEAR;
                    clr_ptr_d = '0;
                    busy_d    = 1'b1;
                end else if (!fifo_empty) begin
                    pop    = 1'b1;
                    we_d   = 1'b1;
                    data_d = head.data;
                    addr_d = head.addr;
                end
            end
            ST_CLEAR: begin
                we_d   = 1'b1;
                data_d = FILL_CHAR;
                addr_d = clr_ptr_q;
                if (clr_ptr_q == LAST_ADDR) begin
                    state_d   = ST_IDLE;
                    clr_ptr_d = '0;
                    busy_d    = 1'b0;
                end else begin
                    clr_ptr_d = clr_ptr_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d   = ST_IDLE;
                clr_ptr_d = '0;
                busy_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q            <= ST_IDLE;
            clr_ptr_q          <= '0;
            gram_write_enable  <= 1'b0;
            gram_write_data    <= '0;
            gram_write_address <= '0;
            clear_busy         <= 1'b0;
        end else begin
            state_q            <= state_d;
            clr_ptr_q          <= clr_ptr_d;
            gram_write_enable  <= we_d;
            gram_write_data    <= data_d;
            gram_write_address <= addr_d;
            clear_busy         <= busy_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= push_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Sticky drop flag; a new drop beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_overflow <= 1'b0;
        end else if (drop) begin
            fifo_overflow <= 1'b1;
        end else if (overflow_clear) begin
            fifo_overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gram_write_scheduler.sv
// Scoreboard bench for gram_write_scheduler: expected GRAM writes are queued
// as stimulus is driven and matched against every observed write strobe.
module tb_gram_write_scheduler;

    localparam int unsigned GRAM_DEPTH = 2400;
    localparam logic [6:0]  FILL_CHAR  = 7'h20;
    localparam int unsigned FIFO_DEPTH = 4;

    typedef struct packed {
        logic [11:0] addr;
        logic [6:0]  data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        uart_write_enable;
    logic [6:0]  uart_write_data;
    logic [11:0] uart_write_address;
    logic        clear_req;
    logic        overflow_clear;
    logic        gram_write_enable;
    logic [6:0]  gram_write_data;
    logic [11:0] gram_write_address;
    logic        clear_busy;
    logic        fifo_overflow;

    exp_t exp_q[$];
    logic [6:0] gram_model [0:4095];
    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int strobe_cnt = 0;
    int busy_cnt = 0;
    int gap_cnt = 0;
    int last_cyc = 0;

    gram_write_scheduler #(
        .GRAM_DEPTH(GRAM_DEPTH),
        .FILL_CHAR (FILL_CHAR),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .uart_write_enable (uart_write_enable),
        .uart_write_data   (uart_write_data),
        .uart_write_address(uart_write_address),
        .clear_req         (clear_req),
        .overflow_clear    (overflow_clear),
        .gram_write_enable (gram_write_enable),
        .gram_write_data   (gram_write_data),
        .gram_write_address(gram_write_address),
        .clear_busy        (clear_busy),
        .fifo_overflow     (fifo_overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Monitor: every strobe must match the head of the expected queue.
    always @(negedge clk) begin
        exp_t e;
        if (clear_busy) busy_cnt++;
        if (gram_write_enable) begin
            if (strobe_cnt > 0 && cyc != last_cyc + 1) gap_cnt++;
            last_cyc = cyc;
            strobe_cnt++;
            gram_model[gram_write_address] = gram_write_data;
            check_eq("strobe_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_eq("strobe_payload", {13'd0, gram_write_address, gram_write_data},
                         {13'd0, e.addr, e.data});
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic reset_stats();
        strobe_cnt = 0;
        busy_cnt   = 0;
        gap_cnt    = 0;
    endtask

    task automatic uart_write(input logic [6:0] d, input logic [11:0] a, input bit accept);
        uart_write_enable  = 1'b1;
        uart_write_data    = d;
        uart_write_address = a;
        if (accept) exp_q.push_back('{addr: a, data: d});
        step();
        uart_write_enable = 1'b0;
    endtask

    task automatic push_fills();
        for (int i = 0; i < int'(GRAM_DEPTH); i++)
            exp_q.push_back('{addr: 12'(i), data: FILL_CHAR});
    endtask

    task automatic start_clear();
        clear_req = 1'b1;
        push_fills();
        step();
        clear_req = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            step();
            n++;
        end
        check_eq("drain_remaining", 32'(exp_q.size()), 32'd0);
        repeat (5) step();
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_we"},   32'(gram_write_enable), 32'd0);
        check_eq({tag, "_data"}, 32'(gram_write_data), 32'd0);
        check_eq({tag, "_addr"}, 32'(gram_write_address), 32'd0);
        check_eq({tag, "_busy"}, 32'(clear_busy), 32'd0);
        check_eq({tag, "_ovf"},  32'(fifo_overflow), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int saved;
        rst = 1'b1;
        uart_write_enable = 1'b0;
        uart_write_data = '0;
        uart_write_address = '0;
        clear_req = 1'b0;
        overflow_clear = 1'b0;
        repeat (3) step();
        check_outputs_zero("reset");
        rst = 1'b0;
        step();

        // Single write: strobe exactly two cycles after the pulse, one cycle wide.
        reset_stats();
        uart_write_enable  = 1'b1;
        uart_write_data    = 7'h41;
        uart_write_address = 12'h005;
        exp_q.push_back('{addr: 12'h005, data: 7'h41});
        step();
        uart_write_enable = 1'b0;
        check_eq("lat_early_we", 32'(gram_write_enable), 32'd0);
        step();
        check_eq("lat_we", 32'(gram_write_enable), 32'd1);
        check_eq("lat_data", 32'(gram_write_data), 32'h41);
        check_eq("lat_addr", 32'(gram_write_address), 32'h005);
        step();
        check_eq("lat_pulse_width", 32'(gram_write_enable), 32'd0);
        check_eq("lat_hold_data", 32'(gram_write_data), 32'h41);
        check_eq("lat_ovf", 32'(fifo_overflow), 32'd0);
        repeat (3) step();
        check_eq("lat_strobes", 32'(strobe_cnt), 32'd1);

        // Full clear.
        reset_stats();
        start_clear();
        check_eq("clr_busy_rise", 32'(clear_busy), 32'd1);
        check_eq("clr_no_strobe_yet", 32'(gram_write_enable), 32'd0);
        step();
        check_eq("clr_first_we", 32'(gram_write_enable), 32'd1);
        check_eq("clr_first_addr", 32'(gram_write_address), 32'd0);
        wait_drain(3000);
        check_eq("clr_strobes", 32'(strobe_cnt), 32'(GRAM_DEPTH));
        check_eq("clr_gaps", 32'(gap_cnt), 32'd0);
        check_eq("clr_busy_cycles", 32'(busy_cnt), 32'(GRAM_DEPTH));
        check_eq("clr_busy_end", 32'(clear_busy), 32'd0);

        // Three UART writes buffered during a clear land right after it.
        reset_stats();
        start_clear();
        repeat (20) step();
        uart_write(7'h61, 12'd10, 1'b1);
        uart_write(7'h62, 12'd20, 1'b1);
        uart_write(7'h63, 12'd30, 1'b1);
        wait_drain(3000);
        check_eq("buf3_strobes", 32'(strobe_cnt), 32'(GRAM_DEPTH + 3));
        check_eq("buf3_gaps", 32'(gap_cnt), 32'd0);
        check_eq("buf3_cell10", 32'(gram_model[10]), 32'h61);
        check_eq("buf3_cell20", 32'(gram_model[20]), 32'h62);
        check_eq("buf3_cell30", 32'(gram_model[30]), 32'h63);
        check_eq("buf3_cell40", 32'(gram_model[40]), 32'(FILL_CHAR));

        // Five writes during a clear: fifth is dropped and flagged.
        reset_stats();
        start_clear();
        repeat (10) step();
        uart_write(7'h31, 12'd100, 1'b1);
        uart_write(7'h32, 12'd101, 1'b1);
        uart_write(7'h33, 12'd102, 1'b1);
        uart_write(7'h34, 12'd103, 1'b1);
        check_eq("ovf_before_drop", 32'(fifo_overflow), 32'd0);
        uart_write(7'h35, 12'd104, 1'b0);
        check_eq("ovf_set", 32'(fifo_overflow), 32'd1);
        wait_drain(3000);
        check_eq("ovf_strobes", 32'(strobe_cnt), 32'(GRAM_DEPTH + 4));
        check_eq("ovf_gaps", 32'(gap_cnt), 32'd0);
        check_eq("ovf_cell104", 32'(gram_model[104]), 32'(FILL_CHAR));
        check_eq("ovf_sticky", 32'(fifo_overflow), 32'd1);
        overflow_clear = 1'b1;
        step();
        overflow_clear = 1'b0;
        check_eq("ovf_cleared", 32'(fifo_overflow), 32'd0);

        // Clear beats a pending entry; a second clear_req mid-clear is ignored.
        reset_stats();
        uart_write_enable  = 1'b1;
        uart_write_data    = 7'h55;
        uart_write_address = 12'h077;
        step();
        uart_write_enable = 1'b0;
        clear_req = 1'b1;
        push_fills();
        exp_q.push_back('{addr: 12'h077, data: 7'h55});
        step();
        clear_req = 1'b0;
        repeat (500) step();
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        wait_drain(3000);
        check_eq("pend_strobes", 32'(strobe_cnt), 32'(GRAM_DEPTH + 1));
        check_eq("pend_busy_cycles", 32'(busy_cnt), 32'(GRAM_DEPTH));
        check_eq("pend_gaps", 32'(gap_cnt), 32'd0);
        check_eq("pend_cell", 32'(gram_model[12'h077]), 32'h55);

        // Reset in the middle of a clear with two buffered writes.
        reset_stats();
        start_clear();
        repeat (5) step();
        uart_write(7'h71, 12'd200, 1'b0);
        uart_write(7'h72, 12'd201, 1'b0);
        n = 0;
        while (!(gram_write_enable && gram_write_address == 12'd1000) && n < 2000) begin
            step();
            n++;
        end
        check_eq("rst_reached_1000", 32'(gram_write_address), 32'd1000);
        rst = 1'b1;
        exp_q.delete();
        step();
        check_outputs_zero("midrst");
        rst = 1'b0;
        saved = strobe_cnt;
        repeat (50) step();
        check_eq("midrst_quiet", 32'(strobe_cnt), 32'(saved));
        check_eq("midrst_busy", 32'(clear_busy), 32'd0);
        uart_write(7'h7e, 12'd5, 1'b1);
        wait_drain(20);
        check_eq("midrst_after", 32'(strobe_cnt), 32'(saved + 1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_errors);
        $finish;
    end

endmodule
